// File: rtl/mm_pkg.sv
// Shared constants and state encoding for the systolic MM array sequencer.
package mm_pkg;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int RW    = 32;
    localparam int K_MAX = 64;
    localparam int AW    = $clog2(K_MAX);
    localparam int RIW   = $clog2(N);
    localparam int WCW   = $clog2(2 * N);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT,
        OUT,
        DONE
    } ctrl_state_e;
endpackage

// File: rtl/mm_skew_buf.sv
// Edge skew buffer: lane i delays its operand by i cycles, carrying a valid bit and zeroing invalid slots.
module mm_skew_buf #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [N*DW-1:0] in_data,
    output logic [N*DW-1:0] out_data
);
    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_pass
            assign out_data[DW-1:0] = in_valid ? in_data[DW-1:0] : '0;
        end else begin : g_chain
            logic [i-1:0]  vld_q, vld_d;
            logic [DW-1:0] dat_q [i];
            logic [DW-1:0] dat_d [i];

            always_comb begin
                vld_d[0] = in_valid;
                dat_d[0] = in_valid ? in_data[i*DW +: DW] : '0;
                for (int s = 1; s < i; s++) begin
                    vld_d[s] = vld_q[s-1];
                    dat_d[s] = dat_q[s-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int s = 0; s < i; s++) dat_q[s] <= '0;
                end else begin
                    vld_q <= vld_d;
                    for (int s = 0; s < i; s++) dat_q[s] <= dat_d[s];
                end
            end

            assign out_data[i*DW +: DW] = vld_q[i-1] ? dat_q[i-1] : '0;
        end
    end
endmodule

// File: rtl/mm_sa_ctrl.sv
// Job sequencer for the NxN output-stationary systolic array: clear, feed K skewed operands, drain, stream rows.
// Optional MM_CTRL_PERF_EN adds a saturating busy-cycle counter output perf_cycles.
module mm_sa_ctrl
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW:0]       k_len,
    output logic              busy,
    output logic              done,
    output logic              a_rd_en,
    output logic              b_rd_en,
    output logic [AW-1:0]     rd_addr,
    input  logic [N*DW-1:0]   a_rd_data,
    input  logic [N*DW-1:0]   b_rd_data,
    output logic              pe_flush,
    output logic [N*DW-1:0]   row_feed,
    output logic [N*DW-1:0]   col_feed,
    input  logic [N*N*RW-1:0] pe_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RIW-1:0]    out_row_idx,
    output logic [N*RW-1:0]   out_data
`ifdef MM_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(2 * N - 2);

    ctrl_state_e    state_q, state_d;
    logic [AW-1:0]  k_q, k_d;
    logic [AW:0]    k_len_q, k_len_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [RIW-1:0] row_q, row_d;
    logic           rd_vld_q, rd_vld_d;
    logic           rd_en;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        k_len_d   = k_len_q;
        wait_d    = wait_q;
        row_d     = row_q;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        pe_flush  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    k_d     = '0;
                    row_d   = '0;
                    k_len_d = (k_len > (AW+1)'(K_MAX)) ? (AW+1)'(K_MAX) : k_len;
                end
            end
            CLEAR: begin
                busy     = 1'b1;
                pe_flush = 1'b1;
                wait_d   = WAIT_LOAD;
                state_d  = (k_len_q == '0) ? WAIT : FEED;
            end
            FEED: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = k_q;
                if ({1'b0, k_q} == k_len_q - (AW+1)'(1)) state_d = WAIT;
                else                                      k_d = k_q + AW'(1);
            end
            WAIT: begin
                // 2N-1 cycles lets the last skewed operand pair reach PE(N-1,N-1).
                busy = 1'b1;
                if (wait_q == '0) begin
                    state_d = OUT;
                    row_d   = '0;
                end else begin
                    wait_d = wait_q - WCW'(1);
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    if (row_q == RIW'(N - 1)) state_d = DONE;
                    else                      row_d   = row_q + RIW'(1);
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                row_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rd_vld_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            k_len_q  <= '0;
            wait_q   <= '0;
            row_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            k_len_q  <= k_len_d;
            wait_q   <= wait_d;
            row_q    <= row_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    assign a_rd_en     = rd_en;
    assign b_rd_en     = rd_en;
    assign out_row_idx = row_q;

    always_comb begin
        out_data = '0;
        for (int j = 0; j < N; j++) begin
            out_data[j*RW +: RW] = pe_res[(int'(row_q) * N + j) * RW +: RW];
        end
    end

    mm_skew_buf #(.N(N), .DW(DW)) u_row_skew (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_vld_q),
        .in_data  (a_rd_data),
        .out_data (row_feed)
    );

    mm_skew_buf #(.N(N), .DW(DW)) u_col_skew (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_vld_q),
        .in_data  (b_rd_data),
        .out_data (col_feed)
    );

`ifdef MM_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE && start) perf_d = '0;
        else if (busy && perf_q != '1) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_mm_sa_ctrl.sv
// Self-checking bench for mm_sa_ctrl with behavioural A/B buffers and an output-stationary PE array model.
module tb_mm_sa_ctrl;
    import mm_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW:0]       k_len;
    logic              busy, done, a_rd_en, b_rd_en, pe_flush, out_valid, out_ready;
    logic [AW-1:0]     rd_addr;
    logic [N*DW-1:0]   a_rd_data = '0;
    logic [N*DW-1:0]   b_rd_data = '0;
    logic [N*DW-1:0]   row_feed, col_feed;
    logic [N*N*RW-1:0] pe_res;
    logic [RIW-1:0]    out_row_idx;
    logic [N*RW-1:0]   out_data;
`ifdef MM_CTRL_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    always #5 clk = ~clk;

    mm_sa_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .busy        (busy),
        .done        (done),
        .a_rd_en     (a_rd_en),
        .b_rd_en     (b_rd_en),
        .rd_addr     (rd_addr),
        .a_rd_data   (a_rd_data),
        .b_rd_data   (b_rd_data),
        .pe_flush    (pe_flush),
        .row_feed    (row_feed),
        .col_feed    (col_feed),
        .pe_res      (pe_res),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row_idx (out_row_idx),
        .out_data    (out_data)
`ifdef MM_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    // Operand buffers, one-cycle read latency
    logic [DW-1:0] amem [K_MAX][N];
    logic [DW-1:0] bmem [K_MAX][N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (a_rd_en) a_rd_data[i*DW +: DW] <= amem[rd_addr][i];
            if (b_rd_en) b_rd_data[i*DW +: DW] <= bmem[rd_addr][i];
        end
    end

    // Output-stationary PE array: operands hop east/south one PE per cycle
    logic [DW-1:0] pa  [N][N];
    logic [DW-1:0] pb  [N][N];
    logic [DW-1:0] ain [N][N];
    logic [DW-1:0] bin [N][N];
    logic [RW-1:0] acc [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ain[i][j] = (j == 0) ? row_feed[i*DW +: DW] : pa[i][(j == 0) ? 0 : j - 1];
                bin[i][j] = (i == 0) ? col_feed[j*DW +: DW] : pb[(i == 0) ? 0 : i - 1][j];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rst || pe_flush) begin
                    acc[i][j] <= '0;
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                end else begin
                    acc[i][j] <= acc[i][j] + RW'(ain[i][j]) * RW'(bin[i][j]);
                    pa[i][j]  <= ain[i][j];
                    pb[i][j]  <= bin[i][j];
                end
            end
        end
    end

    always_comb begin
        pe_res = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                pe_res[(i*N + j)*RW +: RW] = acc[i][j];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [N*RW-1:0] act, input logic [N*RW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [RW-1:0] gold [N][N];

    task automatic fill_and_golden(input int pat, input int kc);
        for (int k = 0; k < K_MAX; k++) begin
            for (int i = 0; i < N; i++) begin
                amem[k][i] = (pat == 0) ? 8'd1 : DW'($urandom_range(0, 255));
                bmem[k][i] = (pat == 0) ? 8'd2 : DW'($urandom_range(0, 255));
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                gold[i][j] = '0;
                for (int k = 0; k < kc; k++) gold[i][j] += RW'(amem[k][i]) * RW'(bmem[k][j]);
            end
        end
    endtask

    function automatic logic [N*RW-1:0] gold_row(input int r);
        logic [N*RW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) v[j*RW +: RW] = gold[r][j];
        return v;
    endfunction

    typedef struct {
        int k_len;
        int pat;
        int stall_row;
        int stall_cyc;
        bit tgl;
        bit spur;
        int exp_rd;
    } vec_t;

    task automatic run_job(input vec_t v);
        int  kc, rd_cnt, busy_cnt, hs, stalls, done_cnt, stall_left, cyc, last_hs_cyc;
        bit  spur_feed, spur_out, fin;
        logic rdy;
        kc = (v.k_len > K_MAX) ? K_MAX : v.k_len;
        fill_and_golden(v.pat, kc);
        rd_cnt = 0; busy_cnt = 0; hs = 0; stalls = 0; done_cnt = 0;
        stall_left = v.stall_cyc; last_hs_cyc = -10;
        spur_feed = 1'b0; spur_out = 1'b0; fin = 1'b0;
        @(negedge clk);
        k_len = (AW+1)'(v.k_len);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < 3000 && !fin; cyc++) begin
            start = 1'b0;
            if (busy) busy_cnt++;
            if (a_rd_en) begin
                check("rd_addr", N*RW'(rd_addr), N*RW'(rd_cnt));
                check("b_rd_en", N*RW'(b_rd_en), N*RW'(1));
                rd_cnt++;
                if (v.spur && !spur_feed && rd_cnt == 3) begin
                    start = 1'b1;
                    spur_feed = 1'b1;
                end
            end
            if (out_valid) begin
                check("out_row_idx", N*RW'(out_row_idx), N*RW'(hs < N ? hs : 0));
                if (hs < N) check("out_data", out_data, gold_row(hs));
                else check("extra_row", N*RW'(hs), N*RW'(N - 1));
                if (hs == v.stall_row && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else if (v.tgl) rdy = ~out_ready;
                else rdy = 1'b1;
                out_ready = rdy;
                if (rdy) begin
                    hs++;
                    last_hs_cyc = cyc;
                end else stalls++;
                if (v.spur && !spur_out) begin
                    start = 1'b1;
                    spur_out = 1'b1;
                end
            end
            if (done) begin
                done_cnt++;
                check("done_after_last_row", N*RW'(cyc), N*RW'(last_hs_cyc + 1));
                fin = 1'b1;
            end
            if (!fin) @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (!fin) check("job_timeout", N*RW'(0), N*RW'(1));
        check("rows_out", N*RW'(hs), N*RW'(N));
        check("rd_count", N*RW'(rd_cnt), N*RW'(v.exp_rd));
        check("busy_cycles", N*RW'(busy_cnt), N*RW'(13 + kc + stalls));
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("idle_busy_done", N*RW'({busy, done, out_valid}), N*RW'(0));
            check("idle_feeds", N*RW'({row_feed, col_feed}), N*RW'(0));
`ifdef MM_CTRL_PERF_EN
            check("perf_cycles", N*RW'(perf_cycles), N*RW'(13 + kc + stalls));
`endif
        end
        check("done_pulses", N*RW'(done_cnt), N*RW'(1));
    endtask

    vec_t vecs[7];
    bit   hit;

    initial begin
        vecs[0] = '{k_len: 1,   pat: 0, stall_row: -1, stall_cyc: 0, tgl: 1'b0, spur: 1'b0, exp_rd: 1};
        vecs[1] = '{k_len: 16,  pat: 1, stall_row: 1,  stall_cyc: 5, tgl: 1'b1, spur: 1'b0, exp_rd: 16};
        vecs[2] = '{k_len: 5,   pat: 1, stall_row: -1, stall_cyc: 0, tgl: 1'b0, spur: 1'b1, exp_rd: 5};
        vecs[3] = '{k_len: 0,   pat: 1, stall_row: -1, stall_cyc: 0, tgl: 1'b0, spur: 1'b0, exp_rd: 0};
        vecs[4] = '{k_len: 100, pat: 1, stall_row: -1, stall_cyc: 0, tgl: 1'b0, spur: 1'b0, exp_rd: 64};
        vecs[5] = '{k_len: 8,   pat: 1, stall_row: -1, stall_cyc: 0, tgl: 1'b0, spur: 1'b0, exp_rd: 8};
        vecs[6] = '{k_len: 64,  pat: 1, stall_row: 3,  stall_cyc: 2, tgl: 1'b1, spur: 1'b0, exp_rd: 64};

        rst = 1'b1; start = 1'b0; k_len = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ctrl", N*RW'({busy, done, a_rd_en, b_rd_en, pe_flush, out_valid}), N*RW'(0));
        check("rst_addr_row", N*RW'({rd_addr, out_row_idx}), N*RW'(0));
        check("rst_feeds", N*RW'({row_feed, col_feed}), N*RW'(0));
`ifdef MM_CTRL_PERF_EN
        check("rst_perf", N*RW'(perf_cycles), N*RW'(0));
`endif
        rst = 1'b0;

        for (int v = 0; v < 7; v++) run_job(vecs[v]);

        // Abort mid-FEED at k=7, then a short job must still be correct
        fill_and_golden(1, 16);
        @(negedge clk);
        k_len = (AW+1)'(16);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (a_rd_en && rd_addr == AW'(7)) hit = 1'b1;
            else @(negedge clk);
        end
        check("reach_k7", N*RW'(hit), N*RW'(1));
        rst = 1'b1;
        @(negedge clk);
        check("abort_ctrl", N*RW'({busy, done, a_rd_en, pe_flush, out_valid}), N*RW'(0));
        check("abort_feeds", N*RW'({row_feed, col_feed}), N*RW'(0));
        check("abort_addr", N*RW'(rd_addr), N*RW'(0));
        rst = 1'b0;
        run_job('{k_len: 3, pat: 1, stall_row: -1, stall_cyc: 0, tgl: 1'b0, spur: 1'b0, exp_rd: 3});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
